// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between the decode path and the ALU op sequencer.
// The master issues ALU requests and consumes responses; the slave is the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 4,
  parameter int STAT_W  = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [FUNCT_W-1:0] req_funct;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               req_keep;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic [STAT_W-1:0]  rsp_stats;
  logic               rsp_err;

  modport master (
    output req_valid, req_funct, req_a, req_b, req_keep, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_stats, rsp_err
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, req_keep, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_stats, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU: sequences one request at a time through the ALU,
// optionally reserving and restoring the ALU status flags around the op.
module alu_op_sequencer #(
  parameter int                 WIDTH   = 32,
  parameter int                 FUNCT_W = 4,
  parameter int                 STAT_W  = 4,
  parameter int                 CNT_W   = 16,
  parameter logic [FUNCT_W-1:0] ALU_ADD = 4'd0,
  parameter logic [FUNCT_W-1:0] ALU_SUB = 4'd1,
  parameter logic [FUNCT_W-1:0] ALU_AND = 4'd2,
  parameter logic [FUNCT_W-1:0] ALU_XOR = 4'd3,
  parameter logic [FUNCT_W-1:0] ALU_NOT = 4'd4,
  parameter logic [FUNCT_W-1:0] ALU_A   = 4'd5,
  parameter logic [FUNCT_W-1:0] ALU_B   = 4'd6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_op_sequencer_if.slave  req_if,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  output logic [FUNCT_W-1:0] o_alu_funct,
  output logic               o_alu_reserve,
  output logic               o_alu_restore,
  input  logic [WIDTH-1:0]   i_alu_r,
  input  logic [STAT_W-1:0]  i_alu_stats,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_op_cnt
);

  typedef enum logic [2:0] {IDLE, RESERVE, ISSUE, FLAGS, RESP} state_t;

  state_t             state_reg;
  logic               keep_reg;
  logic [WIDTH-1:0]   req_a_reg, req_b_reg;
  logic [FUNCT_W-1:0] req_funct_reg;
  logic [WIDTH-1:0]   shadow_a_reg, shadow_b_reg;
  logic [FUNCT_W-1:0] shadow_funct_reg;
  logic [WIDTH-1:0]   alu_a_reg, alu_b_reg;
  logic [FUNCT_W-1:0] alu_funct_reg;
  logic               reserve_reg, restore_reg;
  logic               req_ready_reg, rsp_valid_reg, err_reg, busy_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [STAT_W-1:0]  stats_reg;
  logic [CNT_W-1:0]   cnt_reg;

  function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
    return f inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_NOT, ALU_A, ALU_B};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg        <= IDLE;
      keep_reg         <= 1'b0;
      req_a_reg        <= '0;
      req_b_reg        <= '0;
      req_funct_reg    <= ALU_A;
      shadow_a_reg     <= '0;
      shadow_b_reg     <= '0;
      shadow_funct_reg <= ALU_A;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      alu_funct_reg    <= ALU_A;
      reserve_reg      <= 1'b0;
      restore_reg      <= 1'b0;
      req_ready_reg    <= 1'b1;
      rsp_valid_reg    <= 1'b0;
      err_reg          <= 1'b0;
      busy_reg         <= 1'b0;
      result_reg       <= '0;
      stats_reg        <= '0;
      cnt_reg          <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_if.req_valid) begin
            req_a_reg     <= req_if.req_a;
            req_b_reg     <= req_if.req_b;
            req_funct_reg <= req_if.req_funct;
            keep_reg      <= req_if.req_keep;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (!funct_legal(req_if.req_funct)) begin
              // Illegal op never reaches the ALU; the drive stays untouched.
              err_reg       <= 1'b1;
              result_reg    <= '0;
              stats_reg     <= '0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else if (req_if.req_keep) begin
              err_reg     <= 1'b0;
              reserve_reg <= 1'b1;
              state_reg   <= RESERVE;
            end else begin
              err_reg       <= 1'b0;
              alu_a_reg     <= req_if.req_a;
              alu_b_reg     <= req_if.req_b;
              alu_funct_reg <= req_if.req_funct;
              state_reg     <= ISSUE;
            end
          end
        end
        RESERVE: begin
          // ALU saves flags of the held drive this cycle; remember that drive.
          shadow_a_reg     <= alu_a_reg;
          shadow_b_reg     <= alu_b_reg;
          shadow_funct_reg <= alu_funct_reg;
          alu_a_reg        <= req_a_reg;
          alu_b_reg        <= req_b_reg;
          alu_funct_reg    <= req_funct_reg;
          reserve_reg      <= 1'b0;
          state_reg        <= ISSUE;
        end
        ISSUE: begin
          result_reg <= i_alu_r;
          if (keep_reg) begin
            restore_reg   <= 1'b1;
            alu_a_reg     <= shadow_a_reg;
            alu_b_reg     <= shadow_b_reg;
            alu_funct_reg <= shadow_funct_reg;
          end
          state_reg <= FLAGS;
        end
        FLAGS: begin
          stats_reg     <= i_alu_stats;
          restore_reg   <= 1'b0;
          rsp_valid_reg <= 1'b1;
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          state_reg <= RESP;
        end
        RESP: begin
          if (req_if.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_if.req_ready  = req_ready_reg;
  assign req_if.rsp_valid  = rsp_valid_reg;
  assign req_if.rsp_result = result_reg;
  assign req_if.rsp_stats  = stats_reg;
  assign req_if.rsp_err    = err_reg;
  assign o_alu_a           = alu_a_reg;
  assign o_alu_b           = alu_b_reg;
  assign o_alu_funct       = alu_funct_reg;
  assign o_alu_reserve     = reserve_reg;
  assign o_alu_restore     = restore_reg;
  assign o_busy            = busy_reg;
  assign o_op_cnt          = cnt_reg;

endmodule
